// File: rtl/prbs_checker.sv
// prbs_checker
// Self-synchronising serial PRBS checker for link BER testing. It loads the
// predictor from the incoming stream (SEED), confirms the predictor against
// LOCK_CNT consecutive bits (VERIFY), then free-runs the predictor and counts
// mismatches (LOCKED). Too many errors inside one WINDOW drop it back to SEED.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   rx_valid   rx_bit is valid this cycle; everything holds when low
//   rx_bit     received serial bit
//   clear      synchronous clear of err_count and bit_count (wins over +1)
//   locked     high while in LOCKED
//   bit_err    one-cycle pulse: previous valid bit mismatched while LOCKED
//   lock_lost  one-cycle pulse on the LOCKED -> SEED transition
//   err_count  saturating count of LOCKED-mode bit errors
//   bit_count  saturating count of valid bits checked while LOCKED
module prbs_checker #(
   parameter int               WIDTH      = 23,
   parameter logic [WIDTH-1:0] POLY       = 23'h040A1B,
   parameter int               LOCK_CNT   = 32,
   parameter int               WINDOW     = 1024,
   parameter int               ERR_THRESH = 16,
   parameter int               CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx_valid,
   input  logic             rx_bit,
   input  logic             clear,
   output logic             locked,
   output logic             bit_err,
   output logic             lock_lost,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int SEED_W  = $clog2(WIDTH + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = $clog2(WINDOW + 1);
   localparam int WERR_W  = $clog2(ERR_THRESH + 1);

   localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(WIDTH - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(ERR_THRESH);

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } fsm_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   fsm_t               fsm_p0,      fsm_p1;
   logic [WIDTH-1:0]   pstate_p0,   pstate_p1;
   logic [SEED_W-1:0]  seed_cnt_p0, seed_cnt_p1;
   logic [MATCH_W-1:0] match_p0,    match_p1;
   logic [WIN_W-1:0]   win_p0,      win_p1;
   logic [WERR_W-1:0]  werr_p0,     werr_p1;
   logic [WERR_W-1:0]  werr_inc;
   logic [CNT_W-1:0]   err_count_p0, bit_count_p0;
   logic               locked_p0, bit_err_p0, lock_lost_p0;
   logic               expected;
   logic               mismatch;

   // Stage p0: prediction, next-state and counter updates
   always_comb begin
      fsm_p0       = fsm_p1;
      pstate_p0    = pstate_p1;
      seed_cnt_p0  = seed_cnt_p1;
      match_p0     = match_p1;
      win_p0       = win_p1;
      werr_p0      = werr_p1;
      err_count_p0 = err_count;
      bit_count_p0 = bit_count;
      locked_p0    = locked;
      bit_err_p0   = 1'b0;
      lock_lost_p0 = 1'b0;
      expected     = ^(pstate_p1 & POLY);
      mismatch     = rx_bit ^ expected;
      werr_inc     = werr_p1 + WERR_W'(mismatch);

      if (rx_valid) begin
         case (fsm_p1)
            SEED: begin
               pstate_p0 = {pstate_p1[WIDTH-2:0], rx_bit};
               if (seed_cnt_p1 == SEED_LAST) begin
                  fsm_p0      = VERIFY;
                  seed_cnt_p0 = '0;
                  match_p0    = '0;
               end else begin
                  seed_cnt_p0 = seed_cnt_p1 + 1'b1;
               end
            end
            VERIFY: begin
               // Received bits keep feeding the state so a bad seed corrects itself.
               pstate_p0 = {pstate_p1[WIDTH-2:0], rx_bit};
               if (mismatch) begin
                  match_p0 = '0;
               end else if (match_p1 == MATCH_LAST) begin
                  fsm_p0    = LOCKED;
                  locked_p0 = 1'b1;
                  match_p0  = '0;
                  win_p0    = '0;
                  werr_p0   = '0;
               end else begin
                  match_p0 = match_p1 + 1'b1;
               end
            end
            LOCKED: begin
               // Free-running: the prediction, not rx_bit, is shifted in so a
               // received error never multiplies.
               pstate_p0    = {pstate_p1[WIDTH-2:0], expected};
               bit_count_p0 = sat_inc(bit_count);
               if (mismatch) begin
                  bit_err_p0   = 1'b1;
                  err_count_p0 = sat_inc(err_count);
               end
               // Threshold check comes first so a hit on the last window bit
               // still drops lock.
               if (werr_inc == WERR_LIMIT) begin
                  fsm_p0       = SEED;
                  seed_cnt_p0  = '0;
                  locked_p0    = 1'b0;
                  lock_lost_p0 = 1'b1;
                  win_p0       = '0;
                  werr_p0      = '0;
               end else if (win_p1 == WIN_LAST) begin
                  win_p0  = '0;
                  werr_p0 = '0;
               end else begin
                  win_p0  = win_p1 + 1'b1;
                  werr_p0 = werr_inc;
               end
            end
            default: fsm_p0 = SEED;
         endcase
      end

      if (clear) begin
         err_count_p0 = '0;
         bit_count_p0 = '0;
      end
   end

   // Stage p1: registered state and outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_p1      <= SEED;
         pstate_p1   <= '1;
         seed_cnt_p1 <= '0;
         match_p1    <= '0;
         win_p1      <= '0;
         werr_p1     <= '0;
         err_count   <= '0;
         bit_count   <= '0;
         locked      <= 1'b0;
         bit_err     <= 1'b0;
         lock_lost   <= 1'b0;
      end else begin
         fsm_p1      <= fsm_p0;
         pstate_p1   <= pstate_p0;
         seed_cnt_p1 <= seed_cnt_p0;
         match_p1    <= match_p0;
         win_p1      <= win_p0;
         werr_p1     <= werr_p0;
         err_count   <= err_count_p0;
         bit_count   <= bit_count_p0;
         locked      <= locked_p0;
         bit_err     <= bit_err_p0;
         lock_lost   <= lock_lost_p0;
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
// Bench for prbs_checker: directed streams from a reference generator, a
// behavioural model of lock / window / counter rules, a per-cycle compare
// of every output, and literal expectations for lock time and counts.
module tb_prbs_checker;

   localparam int               WIDTH      = 23;
   localparam logic [WIDTH-1:0] POLY       = 23'h040A1B;
   localparam int               LOCK_CNT   = 32;
   localparam int               WINDOW     = 1024;
   localparam int               ERR_THRESH = 16;
   localparam int               CNT_W      = 32;
   localparam int               LOCK_BITS  = 55;

   localparam int MODE_SEED   = 0;
   localparam int MODE_VERIFY = 1;
   localparam int MODE_LOCKED = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             rx_valid = 1'b0;
   logic             rx_bit = 1'b0;
   logic             clear = 1'b0;
   logic             locked, bit_err, lock_lost;
   logic [CNT_W-1:0] err_count, bit_count;

   int checks = 0;
   int errors = 0;
   int pulses_err = 0;
   int pulses_lost = 0;
   bit gen_hist[$];

   always #5 clk = ~clk;

   prbs_checker #(
      .WIDTH(WIDTH), .POLY(POLY), .LOCK_CNT(LOCK_CNT),
      .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_bit(rx_bit),
      .clear(clear), .locked(locked), .bit_err(bit_err), .lock_lost(lock_lost),
      .err_count(err_count), .bit_count(bit_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Next bit of a history queue (newest at the back): XOR of the bits that
   // were received i steps ago for every tap i in POLY.
   function automatic bit predict(input bit h[$]);
      bit p = 1'b0;
      for (int i = 0; i < WIDTH; i++)
         if (POLY[i]) p ^= h[h.size() - 1 - i];
      return p;
   endfunction

   // ---------------- behavioural model ----------------
   int               m_mode = MODE_SEED;
   bit               m_hist[$];
   int               m_seeded = 0, m_run = 0, m_win_bits = 0, m_win_errs = 0;
   bit               m_locked = 1'b0, m_bit_err = 1'b0, m_lost = 1'b0;
   logic [CNT_W-1:0] m_errs = '0, m_bits = '0;

   task automatic model_reset();
      m_hist.delete();
      repeat (WIDTH) m_hist.push_back(1'b1);
      m_mode = MODE_SEED;
      m_seeded = 0; m_run = 0; m_win_bits = 0; m_win_errs = 0;
      m_locked = 1'b0; m_bit_err = 1'b0; m_lost = 1'b0;
      m_errs = '0; m_bits = '0;
   endtask

   task automatic model_step();
      bit p;
      m_bit_err = 1'b0;
      m_lost    = 1'b0;
      if (rx_valid) begin
         p = predict(m_hist);
         case (m_mode)
            MODE_SEED: begin
               m_hist.push_back(rx_bit);
               m_seeded++;
               if (m_seeded == WIDTH) begin
                  m_mode = MODE_VERIFY;
                  m_seeded = 0;
                  m_run = 0;
               end
            end
            MODE_VERIFY: begin
               m_hist.push_back(rx_bit);
               if (rx_bit == p) begin
                  m_run++;
                  if (m_run == LOCK_CNT) begin
                     m_mode = MODE_LOCKED;
                     m_locked = 1'b1;
                     m_win_bits = 0;
                     m_win_errs = 0;
                  end
               end else begin
                  m_run = 0;
               end
            end
            default: begin
               m_hist.push_back(p);
               if (m_bits != '1) m_bits++;
               m_win_bits++;
               if (rx_bit != p) begin
                  m_bit_err = 1'b1;
                  if (m_errs != '1) m_errs++;
                  m_win_errs++;
               end
               if (m_win_errs == ERR_THRESH) begin
                  m_mode = MODE_SEED;
                  m_seeded = 0;
                  m_locked = 1'b0;
                  m_lost = 1'b1;
                  m_win_bits = 0;
                  m_win_errs = 0;
               end else if (m_win_bits == WINDOW) begin
                  m_win_bits = 0;
                  m_win_errs = 0;
               end
            end
         endcase
         while (m_hist.size() > WIDTH) void'(m_hist.pop_front());
      end
      if (clear) begin
         m_errs = '0;
         m_bits = '0;
      end
   endtask

   always @(posedge clk or negedge reset_n)
      if (!reset_n) model_reset();
      else model_step();

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cyc_locked", locked, m_locked);
      chk("cyc_bit_err", bit_err, m_bit_err);
      chk("cyc_lock_lost", lock_lost, m_lost);
      chk("cyc_err_count", err_count, m_errs);
      chk("cyc_bit_count", bit_count, m_bits);
   end

   // ---------------- stimulus ----------------
   task automatic gen_seed(input logic [WIDTH-1:0] s);
      gen_hist.delete();
      for (int i = WIDTH - 1; i >= 0; i--) gen_hist.push_back(s[i]);
   endtask

   task automatic gen_next(output bit b);
      b = predict(gen_hist);
      gen_hist.push_back(b);
      void'(gen_hist.pop_front());
   endtask

   task automatic step(input bit v, input bit flip, input bit clr);
      bit b;
      if (v) begin
         gen_next(b);
         b ^= flip;
      end else begin
         b = 1'($urandom_range(1));
      end
      @(negedge clk); #1;
      rx_valid = v; rx_bit = b; clear = clr;
      @(posedge clk); #1;
      rx_valid = 1'b0; clear = 1'b0;
      pulses_err  += int'(bit_err);
      pulses_lost += int'(lock_lost);
   endtask

   task automatic wait_lock(input string name, input int duty);
      int nvalid = 0;
      for (int cyc = 0; cyc < 2000 && !locked; cyc++) begin
         bit v;
         v = (int'($urandom_range(99)) < duty);
         step(v, 1'b0, 1'b0);
         if (v) nvalid++;
      end
      chk(name, nvalid, LOCK_BITS);
   endtask

   task automatic reset_pulse();
      @(negedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_locked", locked, 0);
      chk("rst_bit_err", bit_err, 0);
      chk("rst_lock_lost", lock_lost, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_bit_count", bit_count, 0);
      #1 reset_n = 1'b1;
      pulses_err = 0;
      pulses_lost = 0;
   endtask

   initial begin
      bit b;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("por_locked", locked, 0);
      chk("por_err_count", err_count, 0);
      chk("por_bit_count", bit_count, 0);
      #1 reset_n = 1'b1;

      // Generator pins: seed 1 gives 1,0,1,0; all-ones seed gives 1.
      gen_seed(23'd1);
      gen_next(b); chk("pin_seed1_b1", b, 1);
      gen_next(b); chk("pin_seed1_b2", b, 0);
      gen_next(b); chk("pin_seed1_b3", b, 1);
      gen_next(b); chk("pin_seed1_b4", b, 0);
      gen_seed('1);
      gen_next(b); chk("pin_ones_b1", b, 1);

      // Clean lock and long clean run
      gen_seed('1);
      wait_lock("lock_time_clean", 100);
      repeat (5000) step(1'b1, 1'b0, 1'b0);
      chk("clean_bit_count", bit_count, 5000);
      chk("clean_err_count", err_count, 0);
      chk("clean_locked", locked, 1);
      chk("clean_err_pulses", pulses_err, 0);

      // Reset mid-LOCKED, relock on a non-trivial stream
      reset_pulse();
      gen_seed(23'h1A2B3C);
      wait_lock("lock_time_after_reset", 100);

      // Single error
      pulses_err = 0;
      repeat (100) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (200) step(1'b1, 1'b0, 1'b0);
      chk("single_err_pulses", pulses_err, 1);
      chk("single_err_count", err_count, 1);
      chk("single_locked", locked, 1);
      chk("single_bit_count", bit_count, 301);

      // clear together with an error
      step(1'b1, 1'b1, 1'b1);
      chk("clear_err_count", err_count, 0);
      chk("clear_bit_count", bit_count, 0);
      chk("clear_locked", locked, 1);
      step(1'b1, 1'b1, 1'b0);
      chk("after_clear_err_count", err_count, 1);

      // Window restart: 15 errors per window, one on the last bit of window 1
      reset_pulse();
      gen_seed(23'h3C5A71);
      wait_lock("lock_time_window", 100);
      for (int p = 1; p <= 2100; p++) begin
         bit f;
         f = (p <= 840 && p % 60 == 0) || p == 1024 ||
             (p >= 1025 && p <= 1725 && (p - 1025) % 50 == 0);
         step(1'b1, f, 1'b0);
      end
      chk("window_err_count", err_count, 30);
      chk("window_locked", locked, 1);
      chk("window_lost_pulses", pulses_lost, 0);
      chk("window_bit_count", bit_count, 2100);

      // Loss of lock with the 16th error on the last bit of a window
      reset_pulse();
      gen_seed(23'h51E0F3);
      wait_lock("lock_time_loss", 100);
      for (int p = 1; p <= WINDOW; p++) step(1'b1, p >= 1009, 1'b0);
      chk("loss_lost_pulses", pulses_lost, 1);
      chk("loss_locked", locked, 0);
      chk("loss_err_count", err_count, 16);
      wait_lock("relock_time", 100);
      chk("relock_err_count_kept", err_count, 16);

      // 30% valid duty: lock time in valid bits only, then gapped checking
      reset_pulse();
      gen_seed(23'h2468AC);
      wait_lock("lock_time_gapped", 30);
      for (int c = 0; c < 400; c++)
         step(int'($urandom_range(99)) < 30, $urandom_range(19) == 0, 1'b0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
